serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 160 ++++++++++++++++
 tb/tb_serial_adder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: captures a, b and cin, adds one bit per clock LSB first, then holds the result until it is consumed.
// Define SERIAL_ADDER_OVF_EN to add the ovf output, which flags signed two's-complement overflow.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             bit_s;
    logic             carry_nxt_s;
    logic             last_s;
    logic             accept_s;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (c & (x | y));
    endfunction

    assign bit_s       = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
    assign carry_nxt_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
    assign last_s      = (cnt_r == LAST_BIT);
    assign accept_s    = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state flop
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand shifters, carry, bit counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    sum     <= {bit_s, sum[WIDTH-1:1]};
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    carry_r <= carry_nxt_s;
                    // Counter parks at the last bit so it never wraps inside RUN
                    if (last_s) begin
                        cout <= carry_nxt_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            ovf <= carry_r ^ carry_nxt_s;
        end else begin
            ovf <= ovf;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: accepts push reference results, a negedge monitor compares whatever the DUT presents.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    int           acc_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           acc_count = 0;
    int           last_acc = -1;
    bit           stream_mode = 1'b0;
    logic         prev_ov = 1'b0;
    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;

    // Reference: plain integer addition and the sign rule for overflow
    function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t        r;
        logic [63:0] t;
        t      = 64'(x) + 64'(y) + 64'(c);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge sampler: records accepts and result handshakes as the DUT sees them
    always @(posedge clk) begin
        cyc++;
        if (!rst && out_valid && out_ready && exp_q.size() > 0) begin
            last_sum  = sum;
            last_cout = cout;
`ifdef SERIAL_ADDER_OVF_EN
            last_ovf  = ovf;
`else
            last_ovf  = 1'b0;
`endif
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
        end
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(ref_model(a, b, cin));
            acc_q.push_back(cyc);
            if (stream_mode && last_acc >= 0) chk("accept_interval", 64'(cyc - last_acc), 64'(W + 2));
            last_acc = cyc;
            acc_count++;
        end
    end

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_in_done", 64'(in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    if (!prev_ov) chk("latency", 64'(cyc - acc_q[0]), 64'(W));
                    chk("sum", 64'(sum), 64'(exp_q[0].sum));
                    chk("cout", 64'(cout), 64'(exp_q[0].cout));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", 64'(ovf), 64'(exp_q[0].ovf));
`endif
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_accept();
        int  n = acc_count;
        bit  got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (acc_count != n) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 64'(acc_count), 64'(n + 1));
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("result_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1'b1;
        wait_accept();
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        do_op(8'hFF, 8'h01, 1'b0);
        chk("ff_01_sum", 64'(last_sum), 64'h00);
        chk("ff_01_cout", 64'(last_cout), 64'd1);
        do_op(8'hA5, 8'h5A, 1'b1);
        chk("a5_5a_sum", 64'(last_sum), 64'h00);
        chk("a5_5a_cout", 64'(last_cout), 64'd1);
        do_op(8'h12, 8'h34, 1'b0);
        chk("12_34_sum", 64'(last_sum), 64'h46);
        chk("12_34_cout", 64'(last_cout), 64'd0);
        do_op(8'h7F, 8'h01, 1'b0);
        chk("7f_01_sum", 64'(last_sum), 64'h80);
        chk("7f_01_cout", 64'(last_cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("7f_01_ovf", 64'(last_ovf), 64'd1);
`endif
        do_op(8'h80, 8'h80, 1'b0);
        chk("80_80_sum", 64'(last_sum), 64'h00);
        chk("80_80_cout", 64'(last_cout), 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("80_80_ovf", 64'(last_ovf), 64'd1);
`endif
        do_op(8'hFF, 8'hFF, 1'b1);
        chk("ff_ff_1_sum", 64'(last_sum), 64'hFF);
        chk("ff_ff_1_cout", 64'(last_cout), 64'd1);

        // Back-pressure: operands churn during RUN, result held for 5 stalled cycles
        out_ready = 1'b0;
        @(negedge clk);
        a = 8'h3C; b = 8'h4B; cin = 1'b1; in_valid = 1'b1;
        wait_accept();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        wait_idle();
        chk("stall_sum", 64'(last_sum), 64'h88);
        chk("stall_cout", 64'(last_cout), 64'd0);

        // Reset during the 4th RUN cycle aborts the operation
        @(negedge clk);
        a = 8'h55; b = 8'h66; cin = 1'b0; in_valid = 1'b1;
        wait_accept();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_sum_cleared", 64'(sum), 64'd0);
        rst = 1'b0;
        do_op(8'h03, 8'h04, 1'b0);
        chk("after_abort_sum", 64'(last_sum), 64'h07);
        chk("after_abort_cout", 64'(last_cout), 64'd0);

        // Streaming: in_valid and out_ready held high, random operands
        out_ready = 1'b1;
        last_acc = -1;
        stream_mode = 1'b1;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wait_accept();
            @(negedge clk);
            if (i == 999) begin
                in_valid = 1'b0;
            end else begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
        end
        stream_mode = 1'b0;
        wait_idle();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
